voting_ballot_collector: RTL and testbench
==========================================

# voting_ballot_collector

Sequential front end for the combinational voting tally. It accepts one ballot per cycle from a serial voter stream over a valid/ready handshake and rejects duplicate votes. It assembles the packed ballot vector that the tally consumes. It also computes the strict-majority decision, so the packed vector and the decision are presented together with a valid/ack handshake.

## Interface
Parameters:
- N_VOTERS, 8, number of voters; one vote bit per voter; must be ≥ 2.
- ID_W, $clog2(N_VOTERS), width of the voter index.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ballot_valid  input  1  a ballot is offered this cycle.
- ballot_id  input  ID_W  index of the voter casting the ballot.
- ballot_vote  input  1  vote value: 1 = yes, 0 = no.
- ballot_ready  output  1  collector accepts ballots; high only in COLLECT.
- close_i  input  1  close the poll early; sampled only in COLLECT.
- dup_err  output  1  one-cycle pulse for an accepted handshake that was ignored.
- p_input  output  N_VOTERS  packed ballot vector; bit i = vote of voter i; 0 if voter i did not vote.
- yes_count  output  $clog2(N_VOTERS+1)  running count of yes votes.
- result_valid  output  1  p_input, yes_count and o are final; held until acknowledged.
- o  output  1  decision: 1 iff 2*yes_count > N_VOTERS.
- result_ack  input  1  consumer has taken the result.

## Operation
- Two states: COLLECT and DONE. Reset state is COLLECT.
- Internal state:
  - voted[N_VOTERS]: per-voter flags.
  - ballots[N_VOTERS]: stored votes.
  - cast_count: number of voters who have voted.
  - yes_count.
- COLLECT:
  - ballot_ready = 1.
  - On ballot_valid & ballot_ready, when voted[ballot_id] = 0 and ballot_id < N_VOTERS:
    - set voted[id] and ballots[id] = ballot_vote;
    - increment cast_count;
    - increment yes_count if ballot_vote = 1.
  - On an accepted handshake where voted[ballot_id] = 1, or ballot_id ≥ N_VOTERS:
    - the ballot is ignored; no state changes;
    - dup_err pulses high on the next cycle.
  - Leave COLLECT for DONE when either:
    - the accepted ballot makes cast_count = N_VOTERS, or
    - close_i = 1 is sampled.
- Simultaneous ballot and close_i in the same cycle: the ballot is applied first, then the poll closes, so the ballot is counted.
- DONE:
  - ballot_ready = 0; ballot_valid and close_i are ignored.
  - result_valid = 1.
  - p_input = ballots; voters who did not vote read as 0 (no).
  - o = (2*yes_count > N_VOTERS). A tie is 0.
- result_ack in DONE clears voted, ballots, cast_count and yes_count, then returns to COLLECT. result_ack outside DONE has no effect.
- Widths:
  - cast_count and yes_count are $clog2(N_VOTERS+1) bits and cannot overflow, because duplicates are rejected.
  - The comparison uses yes_count extended by one bit.

## Timing
- Reset values:
  - ballot_ready = 1, dup_err = 0, p_input = 0, yes_count = 0, result_valid = 0, o = 0.
  - State = COLLECT; all voted flags = 0.
- Reset asserted mid-poll or in DONE: immediately returns every register to its reset value. Partial ballots are discarded.
- Ballot latency:
  - An accepted ballot is visible on p_input[id] and yes_count one cycle after the handshake edge.
  - p_input and yes_count are registered and update live during COLLECT.
- Result latency:
  - result_valid rises on the cycle after the closing handshake edge, whether the poll closed on the final ballot or on close_i.
  - o is registered in the same edge as result_valid.
- dup_err: registered; high for exactly one cycle, the cycle after the offending handshake.
- Acknowledge:
  - result_ack sampled high while result_valid = 1 drops result_valid and clears the outputs on the next cycle.
  - ballot_ready is 1 in that same cycle, so the earliest new ballot is accepted one cycle after the ack edge.
- Throughput: one ballot per cycle in COLLECT; no bubbles between ballots.

## Test plan
- Full poll, N_VOTERS = 8, on consecutive cycles:
  - Stimulus: ids 0..7 with votes 1,1,0,1,0,1,1,0.
  - Expect: result_valid one cycle after the 8th handshake; p_input = 8'b01101011; yes_count = 5; o = 1; ballot_ready = 0.
- Tie, then early close:
  - Stimulus: ids 0,1,2,3 vote 1 and ids 4,5,6,7 vote 0 → expect yes_count = 4, o = 0.
  - Then, after ack, stimulus: ids 2 and 5 vote 1, then close_i → expect p_input = 8'b00100100, yes_count = 2, o = 0.
- Duplicate rejection:
  - Stimulus: id 3 votes 1, then id 3 votes 0.
  - Expect: dup_err pulses one cycle after the second ballot; p_input[3] stays 1; yes_count stays 1.
- Simultaneous ballot and close:
  - Stimulus: id 7 votes 1 in the same cycle as close_i = 1, after ids 0..4 have voted 1.
  - Expect: yes_count = 6, o = 1, p_input = 8'b10011111.
- Ack and back-pressure:
  - Stimulus: hold result_ack = 0 for 10 cycles in DONE, with ballot_valid held high.
  - Expect: result_valid and outputs stable; nothing accepted.
  - Then stimulus: ack → expect all outputs cleared and ballot_ready = 1 one cycle later.
- Mid-poll reset:
  - Stimulus: assert rst asynchronously, between clock edges, after 4 ballots.
  - Expect: p_input = 0, yes_count = 0, result_valid = 0 immediately.
  - Then stimulus: the same ids voting again → expect them accepted without dup_err.

Source files
------------

// File: rtl/voting_ballot_collector_if.sv
// Ballot stream, result and acknowledge signals of the ballot collector.
//   master: voter stream driver and result consumer
//   slave : the collector
interface voting_ballot_collector_if #(
  parameter int N_VOTERS = 8,
  parameter int ID_W     = $clog2(N_VOTERS)
);
  localparam int CW = $clog2(N_VOTERS + 1);

  logic                ballot_valid;
  logic [ID_W-1:0]     ballot_id;
  logic                ballot_vote;
  logic                ballot_ready;
  logic                close_i;
  logic                dup_err;
  logic [N_VOTERS-1:0] p_input;
  logic [CW-1:0]       yes_count;
  logic                result_valid;
  logic                o;
  logic                result_ack;

  modport master (
    output ballot_valid, ballot_id, ballot_vote, close_i, result_ack,
    input  ballot_ready, dup_err, p_input, yes_count, result_valid, o
  );

  modport slave (
    input  ballot_valid, ballot_id, ballot_vote, close_i, result_ack,
    output ballot_ready, dup_err, p_input, yes_count, result_valid, o
  );
endinterface

// File: rtl/voting_ballot_collector.sv
// Ballot collector: accepts one ballot per cycle, rejects repeat or
// out-of-range voters, builds the packed ballot vector and the strict-majority
// decision, and holds them until the consumer acknowledges.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of voting_ballot_collector_if (ballot stream in,
//              p_input/yes_count/o/result_valid out, result_ack in)

// One voter's slot: voted flag and stored vote.
module voting_ballot_slot (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic vote,
  input  logic clr,
  output logic voted,
  output logic ballot
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (clr) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (wr) begin
      voted  <= 1'b1;
      ballot <= vote;
    end
  end
endmodule

module voting_ballot_collector #(
  parameter int N_VOTERS = 8,
  parameter int ID_W     = $clog2(N_VOTERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  voting_ballot_collector_if.slave        bus
);
  localparam int CW = $clog2(N_VOTERS + 1);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t              state, state_nxt;
  logic [N_VOTERS-1:0] voted, ballots;
  logic [CW-1:0]       cast_cnt, cast_nxt, yes_cnt, yes_nxt;
  logic [CW:0]         yes2;
  logic                in_collect, id_ok, take, bad, close, clr, o_nxt, o_q, dup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_collect = (state == COLLECT);
    id_ok      = 32'(bus.ballot_id) < N_VOTERS;
    // ballot_ready is high exactly in COLLECT, so valid alone is the handshake
    take       = in_collect && bus.ballot_valid && id_ok && !voted[bus.ballot_id];
    bad        = in_collect && bus.ballot_valid && !take;
    cast_nxt   = cast_cnt + CW'(take);
    yes_nxt    = yes_cnt + CW'(take && bus.ballot_vote);
    // the same-cycle ballot is folded into cast_nxt/yes_nxt before closing
    close      = in_collect && (bus.close_i || (take && cast_nxt == CW'(N_VOTERS)));
    clr        = (state == DONE) && bus.result_ack;
    yes2       = {yes_nxt, 1'b0};
    o_nxt      = yes2 > (CW+1)'(N_VOTERS);
    if (close)    state_nxt = DONE;
    else if (clr) state_nxt = COLLECT;
  end

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_slot
    voting_ballot_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr     (take && bus.ballot_id == ID_W'(i)),
      .vote   (bus.ballot_vote),
      .clr    (clr),
      .voted  (voted[i]),
      .ballot (ballots[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cast_cnt <= '0;
      yes_cnt  <= '0;
      o_q      <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      dup_q <= bad;
      if (clr) begin
        cast_cnt <= '0;
        yes_cnt  <= '0;
        o_q      <= 1'b0;
      end else begin
        cast_cnt <= cast_nxt;
        yes_cnt  <= yes_nxt;
        if (close) o_q <= o_nxt;
      end
    end
  end

  assign bus.ballot_ready = (state == COLLECT);
  assign bus.result_valid = (state == DONE);
  assign bus.p_input      = ballots;
  assign bus.yes_count    = yes_cnt;
  assign bus.o            = o_q;
  assign bus.dup_err      = dup_q;
endmodule

// File: tb/tb_voting_ballot_collector.sv
module tb_voting_ballot_collector;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voting_ballot_collector_if #(.N_VOTERS(N), .ID_W(IW)) bus ();
  voting_ballot_collector #(.N_VOTERS(N), .ID_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  // reference model: who voted, what they voted, poll open/closed
  bit m_voted[N];
  bit m_ball[N];
  bit m_done;
  bit m_dup;

  function automatic void model_clear();
    foreach (m_voted[i]) begin m_voted[i] = 0; m_ball[i] = 0; end
    m_done = 0;
    m_dup  = 0;
  endfunction

  function automatic int e_yes();
    int c = 0;
    foreach (m_ball[i]) c += (m_voted[i] && m_ball[i]) ? 1 : 0;
    return c;
  endfunction

  function automatic logic [N-1:0] e_p();
    logic [N-1:0] r;
    foreach (m_ball[i]) r[i] = m_voted[i] & m_ball[i];
    return r;
  endfunction

  function automatic bit e_o();
    return m_done && (2 * e_yes() > N);
  endfunction

  function automatic void model_edge(bit v, int id, bit vote, bit cl, bit ack);
    int cnt;
    m_dup = 0;
    if (!m_done) begin
      if (v) begin
        if (id < N && !m_voted[id]) begin m_voted[id] = 1; m_ball[id] = vote; end
        else m_dup = 1;
      end
      cnt = 0;
      foreach (m_voted[i]) cnt += m_voted[i] ? 1 : 0;
      if (cl || (v && cnt == N)) m_done = 1;
    end else if (ack) begin
      foreach (m_voted[i]) begin m_voted[i] = 0; m_ball[i] = 0; end
      m_done = 0;
    end
  endfunction

  // one clock: drive at negedge, edge, model update, land on next negedge
  task automatic cyc(input bit v, input int id, input bit vote, input bit cl, input bit ack);
    bus.ballot_valid = v;
    bus.ballot_id    = IW'(id);
    bus.ballot_vote  = vote;
    bus.close_i      = cl;
    bus.result_ack   = ack;
    @(posedge clk);
    model_edge(v, id, vote, cl, ack);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ballot_valid = 0; bus.ballot_id = '0; bus.ballot_vote = 0;
    bus.close_i = 0; bus.result_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #2;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    checks++; if (bus.ballot_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.ballot_ready); end
    checks++; if (bus.dup_err !== 1'b0) begin failures++; $display("FAIL reset_dup got=%0b exp=0", bus.dup_err); end
    checks++; if (bus.p_input !== 8'h00) begin failures++; $display("FAIL reset_p got=%0h exp=0", bus.p_input); end
    checks++; if (bus.yes_count !== 4'd0) begin failures++; $display("FAIL reset_yes got=%0d exp=0", bus.yes_count); end
    checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%0b exp=0", bus.result_valid); end
    checks++; if (bus.o !== 1'b0) begin failures++; $display("FAIL reset_o got=%0b exp=0", bus.o); end
  endtask

  task automatic test_full_poll();
    bit votes[8] = '{1, 1, 0, 1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL full_early_rv id=%0d got=%0b exp=0", i, bus.result_valid); end
      cyc(1, i, votes[i], 0, 0);
    end
    idle();
    checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL full_rv got=%0b exp=1", bus.result_valid); end
    checks++; if (bus.p_input !== 8'b01101011) begin failures++; $display("FAIL full_p got=%b exp=01101011", bus.p_input); end
    checks++; if (bus.yes_count !== 4'd5) begin failures++; $display("FAIL full_yes got=%0d exp=5", bus.yes_count); end
    checks++; if (bus.o !== 1'b1) begin failures++; $display("FAIL full_o got=%0b exp=1", bus.o); end
    checks++; if (bus.ballot_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.ballot_ready); end
    cyc(0, 0, 0, 0, 1);
    idle();
    checks++; if ({bus.result_valid, bus.ballot_ready, bus.o} !== 3'b010 || bus.p_input !== 8'h00 || bus.yes_count !== 4'd0)
      begin failures++; $display("FAIL full_ack rv=%0b rdy=%0b o=%0b p=%0h yes=%0d exp rv=0 rdy=1 o=0 p=0 yes=0",
        bus.result_valid, bus.ballot_ready, bus.o, bus.p_input, bus.yes_count); end
  endtask

  task automatic test_tie_close();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, i, (i < 4), 0, 0);
    idle();
    checks++; if (bus.yes_count !== 4'd4 || bus.o !== 1'b0 || bus.result_valid !== 1'b1)
      begin failures++; $display("FAIL tie yes=%0d o=%0b rv=%0b exp yes=4 o=0 rv=1", bus.yes_count, bus.o, bus.result_valid); end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 2, 1, 0, 0);
    cyc(1, 5, 1, 0, 0);
    idle();
    checks++; if (bus.p_input !== 8'b00100100 || bus.result_valid !== 1'b0)
      begin failures++; $display("FAIL live_p p=%b rv=%0b exp p=00100100 rv=0", bus.p_input, bus.result_valid); end
    cyc(0, 0, 0, 1, 0);
    idle();
    checks++; if (bus.p_input !== 8'b00100100 || bus.yes_count !== 4'd2 || bus.o !== 1'b0 || bus.result_valid !== 1'b1)
      begin failures++; $display("FAIL early_close p=%b yes=%0d o=%0b rv=%0b exp p=00100100 yes=2 o=0 rv=1",
        bus.p_input, bus.yes_count, bus.o, bus.result_valid); end
  endtask

  task automatic test_dup();
    do_reset();
    cyc(1, 3, 1, 0, 0);
    checks++; if (bus.dup_err !== 1'b0 || bus.yes_count !== 4'd1)
      begin failures++; $display("FAIL dup_first dup=%0b yes=%0d exp dup=0 yes=1", bus.dup_err, bus.yes_count); end
    cyc(1, 3, 0, 0, 0);
    idle();
    checks++; if (bus.dup_err !== 1'b1) begin failures++; $display("FAIL dup_pulse got=%0b exp=1", bus.dup_err); end
    checks++; if (bus.p_input[3] !== 1'b1 || bus.yes_count !== 4'd1)
      begin failures++; $display("FAIL dup_state p3=%0b yes=%0d exp p3=1 yes=1", bus.p_input[3], bus.yes_count); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.dup_err !== 1'b0) begin failures++; $display("FAIL dup_width got=%0b exp=0", bus.dup_err); end
  endtask

  task automatic test_simul_close();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, i, 1, 0, 0);
    cyc(1, 7, 1, 1, 0);
    idle();
    checks++; if (bus.yes_count !== 4'd6 || bus.o !== 1'b1 || bus.p_input !== 8'b10011111 || bus.result_valid !== 1'b1)
      begin failures++; $display("FAIL simul yes=%0d o=%0b p=%b rv=%0b exp yes=6 o=1 p=10011111 rv=1",
        bus.yes_count, bus.o, bus.p_input, bus.result_valid); end
  endtask

  // continues from the DONE state left by test_simul_close
  task automatic test_back_pressure();
    for (int k = 0; k < 10; k++) begin
      cyc(1, 5, 1, 1, 0);
      checks++; if (bus.result_valid !== 1'b1 || bus.ballot_ready !== 1'b0 || bus.p_input !== 8'b10011111 ||
                    bus.yes_count !== 4'd6 || bus.o !== 1'b1 || bus.dup_err !== 1'b0)
        begin failures++; $display("FAIL hold k=%0d rv=%0b rdy=%0b p=%b yes=%0d o=%0b dup=%0b exp rv=1 rdy=0 p=10011111 yes=6 o=1 dup=0",
          k, bus.result_valid, bus.ballot_ready, bus.p_input, bus.yes_count, bus.o, bus.dup_err); end
    end
    cyc(1, 5, 1, 0, 1);
    checks++; if (bus.result_valid !== 1'b0 || bus.ballot_ready !== 1'b1 || bus.p_input !== 8'h00 || bus.yes_count !== 4'd0 || bus.o !== 1'b0)
      begin failures++; $display("FAIL ack_clear rv=%0b rdy=%0b p=%h yes=%0d o=%0b exp rv=0 rdy=1 p=0 yes=0 o=0",
        bus.result_valid, bus.ballot_ready, bus.p_input, bus.yes_count, bus.o); end
    cyc(1, 5, 1, 0, 0);
    idle();
    checks++; if (bus.p_input !== 8'b00100000 || bus.yes_count !== 4'd1)
      begin failures++; $display("FAIL post_ack_ballot p=%b yes=%0d exp p=00100000 yes=1", bus.p_input, bus.yes_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i, 1, 0, 0);
    idle();
    #2;
    rst = 1;
    #1;
    checks++; if (bus.p_input !== 8'h00 || bus.yes_count !== 4'd0 || bus.result_valid !== 1'b0 || bus.ballot_ready !== 1'b1)
      begin failures++; $display("FAIL async_rst p=%h yes=%0d rv=%0b rdy=%0b exp p=0 yes=0 rv=0 rdy=1",
        bus.p_input, bus.yes_count, bus.result_valid, bus.ballot_ready); end
    @(negedge clk);
    rst = 0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      cyc(1, i, 1, 0, 0);
      checks++; if (bus.dup_err !== 1'b0 || bus.p_input !== e_p())
        begin failures++; $display("FAIL revote id=%0d dup=%0b p=%b exp dup=0 p=%b", i, bus.dup_err, bus.p_input, e_p()); end
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(3, 0) != 0), int'($urandom_range(N - 1, 0)), 1'($urandom_range(1, 0)),
          ($urandom_range(15, 0) == 0), ($urandom_range(2, 0) == 0));
      checks++; if (bus.p_input !== e_p() || bus.yes_count !== CW'(e_yes()) || bus.o !== e_o() ||
                    bus.result_valid !== m_done || bus.ballot_ready !== !m_done || bus.dup_err !== m_dup)
        begin failures++; $display("FAIL rand k=%0d p=%b yes=%0d o=%0b rv=%0b rdy=%0b dup=%0b exp p=%b yes=%0d o=%0b rv=%0b rdy=%0b dup=%0b",
          k, bus.p_input, bus.yes_count, bus.o, bus.result_valid, bus.ballot_ready, bus.dup_err,
          e_p(), e_yes(), e_o(), m_done, !m_done, m_dup); end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    model_clear();
    #3;
    test_reset();
    @(negedge clk);
    rst = 0;
    test_full_poll();
    test_tie_close();
    test_dup();
    test_simul_close();
    test_back_pressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
